// File: rtl/game_timer_plus.sv
// Game timer with packed-BCD hh:mm:ss, count-up/countdown modes, pause, freeze and load.
// A one-second prescaler runs only in RUN; expiry and saturation latch time_up.
module game_timer_plus #(
  parameter int CLK_HZ     = 50000000,
  parameter int HOUR_LIMIT = 99
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       is_game_over,
  input  logic       pause,
  input  logic       count_down,
  input  logic       load,
  input  logic [7:0] load_hours,
  input  logic [7:0] load_minutes,
  input  logic [7:0] load_seconds,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       tick,
  output logic       time_up,
  output logic       running
);

  localparam int            PW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]    HLIM = 8'(((HOUR_LIMIT / 10) * 16) + (HOUR_LIMIT % 10));

  typedef enum logic [1:0] {RUN, HOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hrs_q, hrs_d, min_q, min_d, sec_q, sec_d;
  logic          tick_q, tick_d, timeUp_q, timeUp_d;
  logic [7:0]    hrsClamp;

  function automatic logic [3:0] clampDig(input logic [3:0] d, input logic [3:0] maxD);
    return (d > maxD) ? maxD : d;
  endfunction

  function automatic logic [7:0] incBcd(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] decBcd(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign hrsClamp = {clampDig(load_hours[7:4], 4'd9), clampDig(load_hours[3:0], 4'd9)};

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    hrs_d    = hrs_q;
    min_d    = min_q;
    sec_d    = sec_q;
    timeUp_d = timeUp_q;
    tick_d   = 1'b0;
    if (load) begin
      sec_d    = {clampDig(load_seconds[7:4], 4'd5), clampDig(load_seconds[3:0], 4'd9)};
      min_d    = {clampDig(load_minutes[7:4], 4'd5), clampDig(load_minutes[3:0], 4'd9)};
      hrs_d    = (hrsClamp > HLIM) ? HLIM : hrsClamp;
      presc_d  = '0;
      timeUp_d = 1'b0;
      state_d  = pause ? HOLD : RUN;
    end else if (is_game_over && state_q != DONE) begin
      state_d = DONE;
    end else if (state_q == HOLD) begin
      if (!pause) state_d = RUN;
    end else if (state_q == RUN) begin
      // A step coinciding with pause is dropped; the prescaler stays at its last count.
      if (pause) begin
        state_d = HOLD;
      end else if (presc_q != PMAX) begin
        presc_d = presc_q + PW'(1);
      end else begin
        presc_d = '0;
        if (!count_down) begin
          if (hrs_q == HLIM && min_q == 8'h59 && sec_q == 8'h59) begin
            timeUp_d = 1'b1;
            state_d  = DONE;
          end else begin
            tick_d = 1'b1;
            if (sec_q == 8'h59) begin
              sec_d = 8'h00;
              if (min_q == 8'h59) begin
                min_d = 8'h00;
                hrs_d = incBcd(hrs_q);
              end else begin
                min_d = incBcd(min_q);
              end
            end else begin
              sec_d = incBcd(sec_q);
            end
          end
        end else begin
          if (hrs_q == 8'h00 && min_q == 8'h00 && sec_q == 8'h00) begin
            timeUp_d = 1'b1;
            state_d  = DONE;
          end else begin
            tick_d = 1'b1;
            if (sec_q == 8'h00) begin
              sec_d = 8'h59;
              if (min_q == 8'h00) begin
                min_d = 8'h59;
                hrs_d = decBcd(hrs_q);
              end else begin
                min_d = decBcd(min_q);
              end
            end else begin
              sec_d = decBcd(sec_q);
            end
            if (hrs_q == 8'h00 && min_q == 8'h00 && sec_q == 8'h01) begin
              timeUp_d = 1'b1;
              state_d  = DONE;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      presc_q  <= '0;
      hrs_q    <= 8'h00;
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
      tick_q   <= 1'b0;
      timeUp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hrs_q    <= hrs_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      tick_q   <= tick_d;
      timeUp_q <= timeUp_d;
    end
  end

  assign hours   = hrs_q;
  assign minutes = min_q;
  assign seconds = sec_q;
  assign tick    = tick_q;
  assign time_up = timeUp_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_game_timer_plus.sv
// Directed bench for game_timer_plus (CLK_HZ=4) with a queue of expected values;
// a second instance with HOUR_LIMIT=1 covers saturation and hours clamping.
module tb_game_timer_plus;

  logic       CLOCK_50 = 1'b0;
  logic       reset, isGameOver, pause, countDown, load;
  logic [7:0] loadHours, loadMinutes, loadSeconds;
  logic [7:0] hours, minutes, seconds;
  logic       tick, timeUp, running;

  logic       resetB, loadB;
  logic [7:0] loadHoursB, loadMinutesB, loadSecondsB;
  logic [7:0] hoursB, minutesB, secondsB;
  logic       tickB, timeUpB, runningB;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } expT;

  expT sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  tickCount = 0;
  int  t0;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_timer_plus #(.CLK_HZ(4), .HOUR_LIMIT(99)) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .is_game_over(isGameOver), .pause(pause),
    .count_down(countDown), .load(load), .load_hours(loadHours),
    .load_minutes(loadMinutes), .load_seconds(loadSeconds), .hours(hours),
    .minutes(minutes), .seconds(seconds), .tick(tick), .time_up(timeUp),
    .running(running)
  );

  game_timer_plus #(.CLK_HZ(4), .HOUR_LIMIT(1)) u_lim (
    .CLOCK_50(CLOCK_50), .reset(resetB), .is_game_over(1'b0), .pause(1'b0),
    .count_down(1'b0), .load(loadB), .load_hours(loadHoursB),
    .load_minutes(loadMinutesB), .load_seconds(loadSecondsB), .hours(hoursB),
    .minutes(minutesB), .seconds(secondsB), .tick(tickB), .time_up(timeUpB),
    .running(runningB)
  );

  always begin
    @(posedge CLOCK_50);
    #2;
    if (tick === 1'b1) tickCount++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] timeA();
    return {8'h00, hours, minutes, seconds};
  endfunction

  function automatic logic [31:0] flagsA();
    return {29'b0, timeUp, running, tick};
  endfunction

  function automatic logic [31:0] timeB();
    return {8'h00, hoursB, minutesB, secondsB};
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #3;
  endtask

  task automatic expectVal(input string tag, input logic [31:0] v);
    sbq.push_back('{tag, v});
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expT e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: observed %0h expected an entry", observed);
    end else begin
      e = sbq.pop_front();
      assert (observed === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, observed, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                               input logic cd, input logic ps);
    loadHours   = h;
    loadMinutes = m;
    loadSeconds = s;
    countDown   = cd;
    pause       = ps;
    load        = 1'b1;
    waitCycles(1);
    load        = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    loadHoursB   = h;
    loadMinutesB = m;
    loadSecondsB = s;
    loadB        = 1'b1;
    waitCycles(1);
    loadB        = 1'b0;
  endtask

  initial begin
    int  n;
    logic got;
    reset = 1'b0; resetB = 1'b0; isGameOver = 1'b0; pause = 1'b0; countDown = 1'b0;
    load = 1'b0; loadHours = '0; loadMinutes = '0; loadSeconds = '0;
    loadB = 1'b0; loadHoursB = '0; loadMinutesB = '0; loadSecondsB = '0;
    #1;
    reset = 1'b1; resetB = 1'b1;
    #1;
    expectVal("rstTime", 32'h000000);
    expectVal("rstFlags", 32'b010);
    checkOutput(timeA());
    checkOutput(flagsA());

    // Count up one minute from reset.
    @(posedge CLOCK_50);
    #3;
    reset = 1'b0; resetB = 1'b0;
    t0 = tickCount;
    expectVal("upTime", 32'h000100);
    expectVal("upTicks", 32'd60);
    expectVal("upFlags", 32'b011);
    waitCycles(240);
    checkOutput(timeA());
    checkOutput(32'(tickCount - t0));
    checkOutput(flagsA());

    // Countdown from one minute to expiry.
    applyStimulus(8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
    t0 = tickCount;
    expectVal("downTime", 32'h000000);
    expectVal("downTicks", 32'd60);
    expectVal("downFlags", 32'b101);
    waitCycles(240);
    checkOutput(timeA());
    checkOutput(32'(tickCount - t0));
    checkOutput(flagsA());
    t0 = tickCount;
    expectVal("doneNoTick", 32'd0);
    waitCycles(100);
    checkOutput(32'(tickCount - t0));

    // Pause in the middle of a second keeps the partial count.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    waitCycles(2);
    pause = 1'b1;
    t0 = tickCount;
    expectVal("pauseTicks", 32'd0);
    expectVal("pauseFlags", 32'b000);
    waitCycles(100);
    checkOutput(32'(tickCount - t0));
    checkOutput(flagsA());
    pause = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      waitCycles(1);
      n++;
      if (tick === 1'b1) got = 1'b1;
    end
    expectVal("resumeLatency", 32'd1);
    expectVal("resumeTime", 32'h000001);
    checkOutput(32'(got && n >= 2 && n <= 3));
    checkOutput(timeA());

    // Game over freezes the value without setting time_up.
    applyStimulus(8'h00, 8'h00, 8'h10, 1'b0, 1'b0);
    isGameOver = 1'b1;
    waitCycles(3);
    isGameOver = 1'b0;
    t0 = tickCount;
    expectVal("overTime", 32'h000010);
    expectVal("overFlags", 32'b000);
    expectVal("overTicks", 32'd0);
    waitCycles(1000);
    checkOutput(timeA());
    checkOutput(flagsA());
    checkOutput(32'(tickCount - t0));

    // Clamping of invalid BCD on load, out of DONE into HOLD.
    expectVal("clampTime", 32'h993959);
    expectVal("clampFlags", 32'b000);
    applyStimulus(8'hFF, 8'h3C, 8'h7A, 1'b0, 1'b1);
    checkOutput(timeA());
    checkOutput(flagsA());

    // Load wins over a simultaneous game over, which then applies next cycle.
    isGameOver = 1'b1;
    expectVal("ldOverTime", 32'h000005);
    expectVal("ldOverFlags", 32'b010);
    applyStimulus(8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
    checkOutput(timeA());
    checkOutput(flagsA());
    expectVal("ldOverNext", 32'b000);
    waitCycles(1);
    checkOutput(flagsA());
    isGameOver = 1'b0;

    // Countdown step at zero saturates silently.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    t0 = tickCount;
    expectVal("zeroTime", 32'h000000);
    expectVal("zeroFlags", 32'b100);
    expectVal("zeroTicks", 32'd0);
    waitCycles(4);
    checkOutput(timeA());
    checkOutput(flagsA());
    checkOutput(32'(tickCount - t0));

    // Borrow across hours and carry into hours.
    applyStimulus(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    expectVal("borrow", 32'h005959);
    waitCycles(4);
    checkOutput(timeA());
    applyStimulus(8'h09, 8'h59, 8'h59, 1'b0, 1'b0);
    expectVal("carry", 32'h100000);
    waitCycles(4);
    checkOutput(timeA());

    // Step coinciding with pause is discarded; prescaler stays at its last count.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    waitCycles(3);
    pause = 1'b1;
    expectVal("stepPauseFlags", 32'b000);
    expectVal("stepPauseTime", 32'h000000);
    waitCycles(1);
    checkOutput(flagsA());
    checkOutput(timeA());
    waitCycles(5);
    pause = 1'b0;
    expectVal("unpauseEdge", 32'h000000);
    waitCycles(1);
    checkOutput(timeA());
    expectVal("unpauseStep", 32'h000001);
    waitCycles(1);
    checkOutput(timeA());

    // Asynchronous reset while in DONE, then fresh counting with no carry-over.
    applyStimulus(8'h00, 8'h00, 8'h30, 1'b1, 1'b0);
    waitCycles(2);
    isGameOver = 1'b1;
    waitCycles(1);
    isGameOver = 1'b0;
    countDown = 1'b0;
    reset = 1'b1;
    #1;
    expectVal("asyncTime", 32'h000000);
    expectVal("asyncFlags", 32'b010);
    checkOutput(timeA());
    checkOutput(flagsA());
    waitCycles(1);
    reset = 1'b0;
    expectVal("postRst3", 32'h000000);
    waitCycles(3);
    checkOutput(timeA());
    expectVal("postRst4", 32'h000001);
    waitCycles(1);
    checkOutput(timeA());

    // Hour limit of 1: saturation and hours clamping.
    applyStimulusB(8'h01, 8'h59, 8'h58);
    expectVal("limStep", 32'h015959);
    waitCycles(4);
    checkOutput(timeB());
    expectVal("limHold", 32'h015959);
    expectVal("limFlags", 32'b100);
    waitCycles(4);
    checkOutput(timeB());
    checkOutput({29'b0, timeUpB, runningB, tickB});
    expectVal("limClamp", 32'h010000);
    applyStimulusB(8'h05, 8'h00, 8'h00);
    checkOutput(timeB());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
